bus_hold_arbiter: RTL

Shares the 8088 local bus (address latch, transceiver, MEMORY/IO devices) between the CPU and up to NREQ external bus masters (DMA-style agents).
- Requests bus mastership from the CPU through the HOLD/HLDA handshake.
- Grants the bus to one requester at a time in round-robin order.
- Returns the bus cleanly to the CPU.
- Sits between the requesters and the Intel8088 HOLD/HLDA pins in the top-level bench.

---
 rtl/bus_arb_pkg.sv | 34 +++
 rtl/rr_picker.sv | 40 ++++
 rtl/bus_hold_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the 8088 bus hold arbiter.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (tenure limit with requester masking).
package bus_arb_pkg;

  // Arbiter sequencing: the bus only changes hands through REQ_HOLD/GRANT,
  // and always goes back to the CPU through RELEASE/GAP.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_HOLD = 3'd1,
    GRANT    = 3'd2,
    RELEASE  = 3'd3,
    GAP      = 3'd4
  } arb_state_t;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_MAX_TENURE = 64;
  localparam int DEF_GAP_CYCLES = 2;

  // Width of a requester index; never below one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..n-1; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tenure counter is at least 8 bits wide regardless of MAX_TENURE.
  function automatic int tenure_w(input int n);
    return (cnt_w(n) > 8) ? cnt_w(n) : 8;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first eligible requester
// at or above the pointer, wrapping modulo NREQ.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]          elig_i,
  input  logic [owner_w(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]          win_oh_o,
  output logic [owner_w(NREQ)-1:0] win_idx_o,
  output logic                     valid_o
);

  localparam int IW = owner_w(NREQ);

  // ptr + offset stays below 2*NREQ, so one conditional subtract wraps it.
  logic [IW:0] slot;

  // Scan from the farthest offset down so the nearest eligible slot wins.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    slot      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      slot = {1'b0, ptr_i} + (IW + 1)'(off);
      if (slot >= (IW + 1)'(NREQ)) begin
        slot = slot - (IW + 1)'(NREQ);
      end
      if (elig_i[slot[IW-1:0]]) begin
        win_oh_o                 = '0;
        win_oh_o[slot[IW-1:0]]   = 1'b1;
        win_idx_o                = slot[IW-1:0];
        valid_o                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the 8088 local bus between the CPU and NREQ external masters using
// the HOLD/HLDA handshake, granting one requester per HOLD cycle in
// round-robin order. All outputs are registered.
// Handshake: REQ[i] is a level held by requester i until it is done with the
// bus; GNT[i] is only asserted while HOLD=1 and HLDA=1 were seen; dropping
// REQ[owner] ends the tenure and the bus returns to the CPU.
// Optional feature macro: BUS_ARB_TIMEOUT_EN bounds tenure to MAX_TENURE
// cycles and masks the offending requester until it drops REQ.
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          REQ,
  input  logic                     HLDA,
  output logic                     HOLD,
  output logic [NREQ-1:0]          GNT,
  output logic [owner_w(NREQ)-1:0] OWNER,
  output logic                     BUSY,
  output logic                     PROTO_ERR,
  output logic                     TIMEOUT
);

  localparam int OW = owner_w(NREQ);
  localparam int GW = cnt_w(GAP_CYCLES);

  arb_state_t      state_q, state_d;
  logic            hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;
  logic            tout_q, tout_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_oh;
  logic [OW-1:0]   pick_idx;
  logic            pick_valid;
  logic            tenure_end;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = tenure_w(MAX_TENURE);
  logic [TW-1:0] ten_q, ten_d;
  assign tenure_end = (ten_q == TW'(MAX_TENURE - 1));
`else
  assign tenure_end = 1'b0;
`endif

  assign elig = REQ & ~mask_q;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // Next-state and next-output logic for the bus hold sequence.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    perr_d  = perr_q;
    tout_d  = 1'b0;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
`ifdef BUS_ARB_TIMEOUT_EN
    mask_d  = mask_q & REQ;
    ten_d   = ten_q;
`else
    mask_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        hold_d = 1'b0;
        gnt_d  = '0;
        if (pick_valid) begin
          state_d = REQ_HOLD;
          hold_d  = 1'b1;
        end
      end
      REQ_HOLD: begin
        if (!pick_valid) begin
          state_d = RELEASE;
          hold_d  = 1'b0;
        end else if (HLDA) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + OW'(1);
`ifdef BUS_ARB_TIMEOUT_EN
          ten_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!HLDA || !REQ[owner_q] || tenure_end) begin
          state_d = RELEASE;
          gnt_d   = '0;
          hold_d  = 1'b0;
          tout_d  = tenure_end;
          if (!HLDA) begin
            perr_d = 1'b1;
          end
          if (tenure_end) begin
            mask_d[owner_q] = 1'b1;
          end
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          ten_d = ten_q + TW'(1);
`endif
        end
      end
      RELEASE: begin
        hold_d = 1'b0;
        gnt_d  = '0;
        if (!HLDA) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset returns the bus to the CPU at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      tout_q  <= 1'b0;
      ptr_q   <= '0;
      mask_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      tout_q  <= tout_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      gap_q   <= gap_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Tenure counter for the current grant.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ten_q <= '0;
    end else begin
      ten_q <= ten_d;
    end
  end
`endif

  assign HOLD      = hold_q;
  assign GNT       = gnt_q;
  assign OWNER     = owner_q;
  assign BUSY      = busy_q;
  assign PROTO_ERR = perr_q;
  assign TIMEOUT   = tout_q;

endmodule
